syscall_unit: RTL and testbench
===============================

// Module: syscall_unit
// PURPOSE
//  Services SYSCALL instructions after the hazard unit has drained the pipeline.
//  Consumes the hazard unit's syscall pulse plus the current $v0/$a0 values.
//  Executes the requested service: emits bytes on a ready/valid console stream, or halts.
//  Holds BUSY high so the pipeline stays frozen until the service completes.
// PARAMETERS
//  DATA_WIDTH   32  width of V0_IN / A0_IN (byte count = DATA_WIDTH/8)
//  CNT_WIDTH    16  width of SYSCALL_COUNT (optional feature)
// PORTS
//  CLOCK          in   1            single clock, all state on posedge
//  RESET          in   1            asynchronous, active-low
//  SYSCALL_IN     in   1            one-cycle service request (from hazard unit)
//  V0_IN          in   DATA_WIDTH   service code, sampled with SYSCALL_IN
//  A0_IN          in   DATA_WIDTH   argument, sampled with SYSCALL_IN
//  OUT_READY      in   1            console sink can accept a byte
//  OUT_VALID      out  1            OUT_BYTE is valid
//  OUT_BYTE       out  8            console byte
//  BUSY           out  1            service in progress; pipeline must hold
//  HALT           out  1            sticky: exit service executed
//  ERROR          out  1            sticky: unknown code or request while busy/halted
//  SYSCALL_COUNT  out  CNT_WIDTH    completed services (0 when feature off)
// BEHAVIOUR
//  Reset (RESET=0, async): state IDLE; OUT_VALID=0, OUT_BYTE=0, BUSY=0, HALT=0,
//   ERROR=0, SYSCALL_COUNT=0. Reset mid-service aborts it; no partial bytes retained.
//  States: IDLE, EMIT, DONE.
//  IDLE: on posedge with SYSCALL_IN=1 and HALT=0, latch V0_IN/A0_IN; decode V0[7:0]:
//   11 print char  -> EMIT, 1 byte  = A0[7:0]
//   1  print word  -> EMIT, DATA_WIDTH/8 bytes of A0, MSB byte first
//   10 exit        -> DONE, HALT set at the same edge
//   other          -> DONE, ERROR set, no bytes emitted
//  BUSY=1 in every state except IDLE (visible the cycle after acceptance).
//  EMIT: OUT_VALID=1, OUT_BYTE = current byte. Byte transfers on posedge with
//   OUT_VALID&OUT_READY; OUT_BYTE/OUT_VALID stable while OUT_READY=0 (no timeout).
//   Byte index counter advances per transfer; after last byte -> DONE.
//  DONE: one cycle, BUSY=1, OUT_VALID=0; SYSCALL_COUNT increments (wraps at 2^CNT_WIDTH-1 -> 0); -> IDLE.
//  Latency: print char with OUT_READY=1 -> BUSY high 2 cycles; print word (32b) -> 5 cycles;
//   exit/unknown -> 1 cycle.
//  SYSCALL_IN while BUSY=1, or while HALT=1: request ignored, ERROR set; current service unaffected.
//  SYSCALL_IN in the DONE cycle counts as while-busy (ignored, ERROR).
//  HALT and ERROR clear only on reset. After HALT, unit stays IDLE, BUSY=0.
// CONFIGURATION
//  SYSCALL_COUNT_EN defined: SYSCALL_COUNT counts DONE cycles (all completed services,
//   including exit and unknown codes). Undefined: counter not built, SYSCALL_COUNT tied 0.
// STRUCTURE
//  Shared package (mips_pkg): service code constants SYS_PRINT_WORD=1, SYS_EXIT=10,
//   SYS_PRINT_CHAR=11; state enum typedef {IDLE, EMIT, DONE}.
//  Single module; byte-serialiser (shift register + index counter) inline, no sub-module.
// TESTING
//  1 reset: hold RESET=0 3 cycles with SYSCALL_IN=1 -> all outputs 0, no bytes emitted.
//  2 V0=11, A0=0x41, OUT_READY=1 -> one byte 0x41, BUSY high 2 cycles, COUNT=1 (macro on).
//  3 V0=1, A0=0xDEADBEEF, OUT_READY toggling 1,0,1,0... -> bytes DE,AD,BE,EF in order,
//    OUT_BYTE stable during stalls, no duplicates or drops.
//  4 V0=10 -> HALT=1 next edge; later SYSCALL_IN V0=11 -> no byte, ERROR=1, BUSY stays 0.
//  5 V0=7 -> ERROR=1, no OUT_VALID, BUSY 1 cycle; 2nd SYSCALL_IN during a print-word -> ERROR=1,
//    print completes intact.
//  6 Assert RESET=0 mid print-word (after byte 2) -> OUT_VALID drops immediately, state IDLE;
//    new print-char after release works normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: syscall service codes and the syscall unit state encoding.
package mips_pkg;

    localparam logic [7:0] SYS_PRINT_WORD = 8'd1;
    localparam logic [7:0] SYS_EXIT       = 8'd10;
    localparam logic [7:0] SYS_PRINT_CHAR = 8'd11;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/syscall_unit.sv
// Syscall service unit: prints a char or word on a ready/valid byte stream, or halts.
// Optional completed-service counter built when SYSCALL_COUNT_EN is defined.
module syscall_unit
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  SYSCALL_IN,
    input  logic [DATA_WIDTH-1:0] V0_IN,
    input  logic [DATA_WIDTH-1:0] A0_IN,
    input  logic                  OUT_READY,
    output logic                  OUT_VALID,
    output logic [7:0]            OUT_BYTE,
    output logic                  BUSY,
    output logic                  HALT,
    output logic                  ERROR,
    output logic [CNT_WIDTH-1:0]  SYSCALL_COUNT
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int IDX_WIDTH = $clog2(NUM_BYTES) + 1;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [IDX_WIDTH-1:0]  idx_q, last_q;
    logic                  halt_q, error_q;
    logic [7:0]            code;
    logic                  is_print, accept, collide, xfer, last_byte;
    logic                  unused_v0_bits;

    // Only the low byte of $v0 selects the service.
    assign code           = V0_IN[7:0];
    assign unused_v0_bits = ^V0_IN[DATA_WIDTH-1:8];

    assign is_print  = (code == SYS_PRINT_CHAR) || (code == SYS_PRINT_WORD);
    assign accept    = (state == IDLE) && SYSCALL_IN && !halt_q;
    assign collide   = SYSCALL_IN && ((state != IDLE) || halt_q);
    assign xfer      = (state == EMIT) && OUT_READY;
    assign last_byte = (idx_q == last_q);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: defaults are assigned first so no path leaves a variable unassigned (no latch).
    always_comb begin
        state_next = state;
        OUT_VALID  = 1'b0;
        OUT_BYTE   = 8'h00;
        BUSY       = 1'b1;
        case (state)
            IDLE: begin
                BUSY = 1'b0;
                if (accept) state_next = is_print ? EMIT : DONE;
            end
            EMIT: begin
                OUT_VALID = 1'b1;
                OUT_BYTE  = shift_q[DATA_WIDTH-1 -: 8];
                if (xfer && last_byte) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bytes leave from the top of the shift register, so a print char is loaded MSB-aligned.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            shift_q <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            halt_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            if (collide) error_q <= 1'b1;
            if (accept) begin
                idx_q <= '0;
                if (code == SYS_PRINT_CHAR) begin
                    shift_q <= {A0_IN[7:0], {(DATA_WIDTH-8){1'b0}}};
                    last_q  <= '0;
                end else begin
                    shift_q <= A0_IN;
                    last_q  <= IDX_WIDTH'(NUM_BYTES - 1);
                end
                if (code == SYS_EXIT) halt_q  <= 1'b1;
                else if (!is_print)   error_q <= 1'b1;
            end
            if (xfer) begin
                shift_q <= shift_q << 8;
                idx_q   <= idx_q + 1'b1;
            end
        end
    end

    assign HALT  = halt_q;
    assign ERROR = error_q;

`ifdef SYSCALL_COUNT_EN
    logic [CNT_WIDTH-1:0] count_q;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET)              count_q <= '0;
        else if (state == DONE)  count_q <= count_q + 1'b1;
    end

    assign SYSCALL_COUNT = count_q;
`else
    assign SYSCALL_COUNT = '0;
`endif

endmodule

// File: tb/tb_syscall_unit.sv
// Directed self-checking bench for syscall_unit (works with or without SYSCALL_COUNT_EN).
module tb_syscall_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        syscall_in = 1'b0;
    logic [31:0] v0_in = '0;
    logic [31:0] a0_in = '0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [7:0]  out_byte;
    logic        busy, halt, error;
    logic [15:0] syscall_count;

    int errors = 0;
    int checks = 0;
    logic [7:0] captured[$];

    syscall_unit dut (
        .CLOCK(clk), .RESET(rst_n), .SYSCALL_IN(syscall_in), .V0_IN(v0_in), .A0_IN(a0_in),
        .OUT_READY(out_ready), .OUT_VALID(out_valid), .OUT_BYTE(out_byte), .BUSY(busy),
        .HALT(halt), .ERROR(error), .SYSCALL_COUNT(syscall_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) captured.push_back(out_byte);
    end

    function automatic logic [15:0] exp_cnt(input int n);
`ifdef SYSCALL_COUNT_EN
        return 16'(n);
`else
        return 16'(n * 0);
`endif
    endfunction

    function automatic logic [31:0] packed_bytes();
        logic [31:0] v = '0;
        foreach (captured[i]) v = {v[23:0], captured[i]};
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] v0, input logic [31:0] a0);
        syscall_in = 1'b1; v0_in = v0; a0_in = a0;
        step();
        syscall_in = 1'b0;
    endtask

    task automatic run_busy(input int max, output int cycles);
        cycles = 0;
        while (busy && cycles < max) begin
            cycles++;
            step();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; syscall_in = 1'b0; out_ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step();
        captured.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; syscall_in = 1'b1; v0_in = 32'd11; a0_in = 32'h41; out_ready = 1'b1;
        repeat (3) step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h expected 00", out_byte); end
        checks++; if ({busy, halt, error} !== 3'b000) begin errors++; $display("FAIL reset_flags: busy/halt/error got %b expected 000", {busy, halt, error}); end
        checks++; if (syscall_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", syscall_count); end
        checks++; if (captured.size() !== 0) begin errors++; $display("FAIL reset_bytes: got %0d bytes expected 0", captured.size()); end
        syscall_in = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_print_char();
        int cyc;
        captured.delete();
        issue(32'd11, 32'h0000_0041);
        checks++; if (out_valid !== 1'b1 || out_byte !== 8'h41) begin errors++; $display("FAIL char_out: valid=%b byte=%h expected 1/41", out_valid, out_byte); end
        run_busy(20, cyc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL char_busy: got %0d cycles expected 2", cyc); end
        checks++; if (captured.size() !== 1 || packed_bytes() !== 32'h41) begin errors++; $display("FAIL char_bytes: got %0d bytes %h expected 1 byte 41", captured.size(), packed_bytes()); end
        checks++; if (syscall_count !== exp_cnt(1)) begin errors++; $display("FAIL char_count: got %0d expected %0d", syscall_count, exp_cnt(1)); end
    endtask

    task automatic test_print_word_stall();
        int k = 0;
        logic pv, stall_bad = 1'b0;
        logic [7:0] pb;
        captured.delete();
        issue(32'd1, 32'hDEAD_BEEF);
        while (busy && k < 40) begin
            out_ready = (k % 2 == 0);
            pv = out_valid; pb = out_byte;
            step();
            if (!out_ready && pv && !(out_valid === 1'b1 && out_byte === pb)) stall_bad = 1'b1;
            k++;
        end
        out_ready = 1'b1;
        checks++; if (stall_bad !== 1'b0) begin errors++; $display("FAIL word_stall_stable: got unstable=%b expected 0", stall_bad); end
        checks++; if (k !== 8) begin errors++; $display("FAIL word_stall_busy: got %0d cycles expected 8", k); end
        checks++; if (captured.size() !== 4 || packed_bytes() !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_bytes: got %0d bytes %h expected 4 bytes deadbeef", captured.size(), packed_bytes()); end
        checks++; if (syscall_count !== exp_cnt(2)) begin errors++; $display("FAIL word_count: got %0d expected %0d", syscall_count, exp_cnt(2)); end
    endtask

    task automatic test_unknown();
        int cyc;
        captured.delete();
        issue(32'd7, 32'h1234_5678);
        checks++; if (error !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL unknown_flags: error=%b valid=%b expected 1/0", error, out_valid); end
        run_busy(20, cyc);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL unknown_busy: got %0d cycles expected 1", cyc); end
        checks++; if (captured.size() !== 0 || halt !== 1'b0) begin errors++; $display("FAIL unknown_nobytes: got %0d bytes halt=%b expected 0/0", captured.size(), halt); end
        checks++; if (syscall_count !== exp_cnt(3)) begin errors++; $display("FAIL unknown_count: got %0d expected %0d", syscall_count, exp_cnt(3)); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        do_reset();
        issue(32'd1, 32'h1234_5678);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL b2b_error_before: got %b expected 0", error); end
        issue(32'd11, 32'h0000_0099);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL b2b_error: got %b expected 1", error); end
        run_busy(20, cyc);
        checks++; if (cyc + 1 !== 5) begin errors++; $display("FAIL b2b_busy: got %0d cycles expected 5", cyc + 1); end
        checks++; if (captured.size() !== 4 || packed_bytes() !== 32'h1234_5678) begin errors++; $display("FAIL b2b_bytes: got %0d bytes %h expected 4 bytes 12345678", captured.size(), packed_bytes()); end
        checks++; if (syscall_count !== exp_cnt(1)) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", syscall_count, exp_cnt(1)); end
    endtask

    task automatic test_halt();
        int cyc;
        do_reset();
        issue(32'd10, 32'h0);
        checks++; if (halt !== 1'b1 || busy !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL halt_set: halt/busy/error got %b%b%b expected 110", halt, busy, error); end
        run_busy(20, cyc);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL halt_busy: got %0d cycles expected 1", cyc); end
        issue(32'd11, 32'h0000_0055);
        checks++; if (error !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL halt_reject: error/busy/valid got %b%b%b expected 100", error, busy, out_valid); end
        repeat (3) step();
        checks++; if (busy !== 1'b0 || halt !== 1'b1 || captured.size() !== 0) begin errors++; $display("FAIL halt_idle: busy=%b halt=%b bytes=%0d expected 0/1/0", busy, halt, captured.size()); end
        checks++; if (syscall_count !== exp_cnt(1)) begin errors++; $display("FAIL halt_count: got %0d expected %0d", syscall_count, exp_cnt(1)); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        do_reset();
        issue(32'd1, 32'hCAFE_F00D);
        step(); step();
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_byte !== 8'h00) begin errors++; $display("FAIL mid_reset_out: valid/busy/byte got %b/%b/%h expected 0/0/00", out_valid, busy, out_byte); end
        checks++; if (captured.size() !== 2 || packed_bytes() !== 32'h0000_CAFE) begin errors++; $display("FAIL mid_reset_bytes: got %0d bytes %h expected 2 bytes cafe", captured.size(), packed_bytes()); end
        step();
        rst_n = 1'b1;
        step();
        captured.delete();
        issue(32'd11, 32'h0000_005A);
        run_busy(20, cyc);
        checks++; if (cyc !== 2 || captured.size() !== 1 || packed_bytes() !== 32'h5A) begin errors++; $display("FAIL mid_reset_char: cycles=%0d bytes=%0d value=%h expected 2/1/5a", cyc, captured.size(), packed_bytes()); end
        checks++; if (syscall_count !== exp_cnt(1) || error !== 1'b0) begin errors++; $display("FAIL mid_reset_count: count=%0d error=%b expected %0d/0", syscall_count, error, exp_cnt(1)); end
    endtask

    initial begin
        test_reset();
        test_print_char();
        test_print_word_stall();
        test_unknown();
        test_back_to_back();
        test_halt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
